rx_config_sequencer: RTL and testbench



---
 rtl/rx_config_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_rx_config_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_config_sequencer.sv
// Shadowed runtime config for the RX DSP core: phase increments land on a
// demix-clock boundary, gains optionally ramp (GAIN_RAMP_EN) toward target.
`timescale 1ns/1ps
module rx_config_sequencer #(
   parameter int         ALIGN_PERIOD  = 4,
   parameter int         RAMP_INTERVAL = 16,
   parameter logic [7:0] RESET_GAIN    = 8'd64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cfg_wr_valid,
   output logic        cfg_wr_ready,
   input  logic [3:0]  cfg_wr_addr,
   input  logic [15:0] cfg_wr_data,
   input  logic        commit_req,
   output logic        busy,
   output logic        commit_done,
   output logic        commit_overrun,
   output logic        addr_err,
   output logic [15:0] ddc_phase_inc,
   output logic [15:0] demix_phase_inc,
   output logic [15:0] duc1_phase_inc,
   output logic [15:0] duc2_phase_inc,
   output logic [15:0] duc3_phase_inc,
   output logic [7:0]  gain_duc1,
   output logic [7:0]  gain_duc2,
   output logic [7:0]  gain_duc3
);

   localparam int AW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;

`ifdef GAIN_RAMP_EN
   localparam int SW = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      RAMP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   logic [SW-1:0] step_cnt;

   function automatic logic [7:0] step_toward(
      input logic [7:0] cur,
      input logic [7:0] tgt
   );
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      DONE  = 2'd3
   } state_t;
`endif

   state_t        state;
   logic [AW-1:0] align_cnt;
   logic          wr_acc;

   logic [15:0] phase_sh   [5];
   logic [15:0] phase_nxt  [5];
   logic [15:0] snap_phase [5];
   logic [7:0]  gain_sh    [3];
   logic [7:0]  gain_nxt   [3];
   logic [7:0]  snap_gain  [3];

   assign wr_acc = cfg_wr_valid && cfg_wr_ready;

   // Next shadow contents; the snapshot uses these so a same-cycle write is included
   always_comb begin
      phase_nxt = phase_sh;
      gain_nxt  = gain_sh;
      if (wr_acc) begin
         case (cfg_wr_addr)
            4'd0:    phase_nxt[0] = cfg_wr_data;
            4'd1:    phase_nxt[1] = cfg_wr_data;
            4'd2:    phase_nxt[2] = cfg_wr_data;
            4'd3:    phase_nxt[3] = cfg_wr_data;
            4'd4:    phase_nxt[4] = cfg_wr_data;
            4'd5:    gain_nxt[0]  = cfg_wr_data[7:0];
            4'd6:    gain_nxt[1]  = cfg_wr_data[7:0];
            4'd7:    gain_nxt[2]  = cfg_wr_data[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 5; i++)
            phase_sh[i] <= '0;
         for (int i = 0; i < 3; i++)
            gain_sh[i] <= RESET_GAIN;
      end else begin
         phase_sh <= phase_nxt;
         gain_sh  <= gain_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         align_cnt       <= '0;
         busy            <= 1'b0;
         cfg_wr_ready    <= 1'b1;
         commit_done     <= 1'b0;
         commit_overrun  <= 1'b0;
         addr_err        <= 1'b0;
         ddc_phase_inc   <= '0;
         demix_phase_inc <= '0;
         duc1_phase_inc  <= '0;
         duc2_phase_inc  <= '0;
         duc3_phase_inc  <= '0;
         gain_duc1       <= RESET_GAIN;
         gain_duc2       <= RESET_GAIN;
         gain_duc3       <= RESET_GAIN;
         for (int i = 0; i < 5; i++)
            snap_phase[i] <= '0;
         for (int i = 0; i < 3; i++)
            snap_gain[i] <= RESET_GAIN;
`ifdef GAIN_RAMP_EN
         step_cnt <= '0;
`endif
      end else begin
         if (align_cnt == AW'(ALIGN_PERIOD - 1))
            align_cnt <= '0;
         else
            align_cnt <= align_cnt + 1'b1;

         commit_done    <= 1'b0;
         commit_overrun <= commit_req && busy;
         addr_err       <= wr_acc && cfg_wr_addr[3];

         case (state)
            IDLE: begin
               if (commit_req) begin
                  snap_phase   <= phase_nxt;
                  snap_gain    <= gain_nxt;
                  busy         <= 1'b1;
                  cfg_wr_ready <= 1'b0;
                  state        <= ALIGN;
               end
            end

            ALIGN: begin
               if (align_cnt == '0) begin
                  ddc_phase_inc   <= snap_phase[0];
                  demix_phase_inc <= snap_phase[1];
                  duc1_phase_inc  <= snap_phase[2];
                  duc2_phase_inc  <= snap_phase[3];
                  duc3_phase_inc  <= snap_phase[4];
`ifdef GAIN_RAMP_EN
                  step_cnt <= '0;
                  if (gain_duc1 == snap_gain[0] &&
                      gain_duc2 == snap_gain[1] &&
                      gain_duc3 == snap_gain[2])
                     state <= DONE;
                  else
                     state <= RAMP;
`else
                  gain_duc1 <= snap_gain[0];
                  gain_duc2 <= snap_gain[1];
                  gain_duc3 <= snap_gain[2];
                  state     <= DONE;
`endif
               end
            end

`ifdef GAIN_RAMP_EN
            RAMP: begin
               if (step_cnt == SW'(RAMP_INTERVAL - 1)) begin
                  step_cnt  <= '0;
                  gain_duc1 <= step_toward(gain_duc1, snap_gain[0]);
                  gain_duc2 <= step_toward(gain_duc2, snap_gain[1]);
                  gain_duc3 <= step_toward(gain_duc3, snap_gain[2]);
                  if (step_toward(gain_duc1, snap_gain[0]) == snap_gain[0] &&
                      step_toward(gain_duc2, snap_gain[1]) == snap_gain[1] &&
                      step_toward(gain_duc3, snap_gain[2]) == snap_gain[2])
                     state <= DONE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
`endif

            DONE: begin
               commit_done  <= 1'b1;
               busy         <= 1'b0;
               cfg_wr_ready <= 1'b1;
               state        <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_config_sequencer.sv
// Directed bench for rx_config_sequencer; covers both GAIN_RAMP_EN builds.
`timescale 1ns/1ps
module tb_rx_config_sequencer;

   localparam int AP = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        cfg_wr_valid;
   logic        cfg_wr_ready;
   logic [3:0]  cfg_wr_addr;
   logic [15:0] cfg_wr_data;
   logic        commit_req;
   logic        busy;
   logic        commit_done;
   logic        commit_overrun;
   logic        addr_err;
   logic [15:0] ddc_phase_inc;
   logic [15:0] demix_phase_inc;
   logic [15:0] duc1_phase_inc;
   logic [15:0] duc2_phase_inc;
   logic [15:0] duc3_phase_inc;
   logic [7:0]  gain_duc1;
   logic [7:0]  gain_duc2;
   logic [7:0]  gain_duc3;

   int n_chk = 0;
   int n_err = 0;
   int ac    = 0;
   int n_busy, n_rdy_lo, n_done, n_ovr;

   rx_config_sequencer dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_wr_valid    (cfg_wr_valid),
      .cfg_wr_ready    (cfg_wr_ready),
      .cfg_wr_addr     (cfg_wr_addr),
      .cfg_wr_data     (cfg_wr_data),
      .commit_req      (commit_req),
      .busy            (busy),
      .commit_done     (commit_done),
      .commit_overrun  (commit_overrun),
      .addr_err        (addr_err),
      .ddc_phase_inc   (ddc_phase_inc),
      .demix_phase_inc (demix_phase_inc),
      .duc1_phase_inc  (duc1_phase_inc),
      .duc2_phase_inc  (duc2_phase_inc),
      .duc3_phase_inc  (duc3_phase_inc),
      .gain_duc1       (gain_duc1),
      .gain_duc2       (gain_duc2),
      .gain_duc3       (gain_duc3)
   );

   always #5 clock = ~clock;

   // ac tracks the align counter value visible after each edge
   task automatic tick();
      @(posedge clock);
      ac = reset ? 0 : ((ac + 1) % AP);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic sync1();
      for (int i = 0; i < AP && ac != 1; i++)
         tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = a;
      cfg_wr_data  = d;
      tick();
      cfg_wr_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs,
                      input logic [79:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] phases();
      return {ddc_phase_inc, demix_phase_inc, duc1_phase_inc,
              duc2_phase_inc, duc3_phase_inc};
   endfunction

   function automatic logic [79:0] gains();
      return {56'd0, gain_duc1, gain_duc2, gain_duc3};
   endfunction

   initial begin
      reset        = 1'b1;
      cfg_wr_valid = 1'b0;
      cfg_wr_addr  = '0;
      cfg_wr_data  = '0;
      commit_req   = 1'b0;
      ticks(3);
      reset = 1'b0;

      // 1: reset state, writes alone do not reach outputs
      chk("rst_phase", phases(), 80'd0);
      chk("rst_gain", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", cfg_wr_ready, 1'b1);
      chk("rst_done", commit_done, 1'b0);
      wr(4'd0, 16'h1234);
      wr(4'd5, 16'h0050);
      ticks(2);
      chk("wr_no_out_phase", phases(), 80'd0);
      chk("wr_no_out_gain", gains(), {56'd0, 8'd64, 8'd64, 8'd64});

      // 2: aligned phase commit, gains unchanged
      wr(4'd5, 16'd64);
      wr(4'd2, 16'h0800);
      sync1();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      chk("c2_busy", busy, 1'b1);
      chk("c2_ready", cfg_wr_ready, 1'b0);
      chk("c2_ph1", phases(), 80'd0);
      tick();
      chk("c2_ph2", phases(), 80'd0);
      tick();
      chk("c2_ph3", phases(), 80'd0);
      chk("c2_done3", commit_done, 1'b0);
      tick();
      chk("c2_ph4", phases(), {16'h1234, 16'h0, 16'h0800, 16'h0, 16'h0});
      chk("c2_done4", commit_done, 1'b0);
      chk("c2_busy4", busy, 1'b1);
      chk("c2_gain4", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      tick();
      chk("c2_done5", commit_done, 1'b1);
      chk("c2_busy5", busy, 1'b0);
      chk("c2_ready5", cfg_wr_ready, 1'b1);
      tick();
      chk("c2_done6", commit_done, 1'b0);

      // 4: overrun and rejected write while busy
      wr(4'd3, 16'h0333);
      sync1();
      commit_req = 1'b1;
      tick();
      n_busy = 0;
      n_rdy_lo = 0;
      n_done = 0;
      n_ovr = 0;
      commit_req   = 1'b1;
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 4'd3;
      cfg_wr_data  = 16'h0555;
      for (int i = 0; i < 10; i++) begin
         n_busy   += int'(busy);
         n_rdy_lo += int'(!cfg_wr_ready);
         n_done   += int'(commit_done);
         n_ovr    += int'(commit_overrun);
         tick();
         commit_req   = 1'b0;
         cfg_wr_valid = 1'b0;
      end
      chk("c4_busy_cycles", n_busy, 4);
      chk("c4_ready_lo_cycles", n_rdy_lo, 4);
      chk("c4_done_count", n_done, 1);
      chk("c4_overrun_count", n_ovr, 1);
      chk("c4_duc2", duc2_phase_inc, 16'h0333);

      // 5: unmapped write, then same-cycle write plus commit
      wr(4'd9, 16'hFFFF);
      chk("c5_addr_err", addr_err, 1'b1);
      tick();
      chk("c5_addr_err_clr", addr_err, 1'b0);
      chk("c5_ph_hold", phases(),
          {16'h1234, 16'h0, 16'h0800, 16'h0333, 16'h0});
      sync1();
      commit_req   = 1'b1;
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = 4'd2;
      cfg_wr_data  = 16'h0AAA;
      tick();
      commit_req   = 1'b0;
      cfg_wr_valid = 1'b0;
      ticks(3);
      chk("c5_ph", phases(), {16'h1234, 16'h0, 16'h0AAA, 16'h0333, 16'h0});
      chk("c5_gain", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      tick();
      chk("c5_done", commit_done, 1'b1);

      // 3: gain update, up on duc1 and down on duc2
      wr(4'd5, 16'd67);
      wr(4'd6, 16'd62);
      sync1();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
`ifdef GAIN_RAMP_EN
      ticks(18);
      chk("c3_g19", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      tick();
      chk("c3_g20", gains(), {56'd0, 8'd65, 8'd63, 8'd64});
      ticks(15);
      chk("c3_g35", gains(), {56'd0, 8'd65, 8'd63, 8'd64});
      tick();
      chk("c3_g36", gains(), {56'd0, 8'd66, 8'd62, 8'd64});
      ticks(15);
      chk("c3_g51", gains(), {56'd0, 8'd66, 8'd62, 8'd64});
      tick();
      chk("c3_g52", gains(), {56'd0, 8'd67, 8'd62, 8'd64});
      chk("c3_done52", commit_done, 1'b0);
      tick();
      chk("c3_done53", commit_done, 1'b1);
      chk("c3_busy53", busy, 1'b0);
      chk("c3_g53", gains(), {56'd0, 8'd67, 8'd62, 8'd64});
`else
      ticks(2);
      chk("c3_g3", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      tick();
      chk("c3_g4", gains(), {56'd0, 8'd67, 8'd62, 8'd64});
      tick();
      chk("c3_done5", commit_done, 1'b1);
`endif

      // 6: reset mid-commit aborts it
      wr(4'd7, 16'd70);
      wr(4'd4, 16'h0077);
      sync1();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
`ifdef GAIN_RAMP_EN
      ticks(21);
      chk("c6_mid_ramp_busy", busy, 1'b1);
`else
      tick();
      chk("c6_mid_align_busy", busy, 1'b1);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("c6_phase", phases(), 80'd0);
      chk("c6_gain", gains(), {56'd0, 8'd64, 8'd64, 8'd64});
      chk("c6_busy", busy, 1'b0);
      chk("c6_done0", commit_done, 1'b0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_done += int'(commit_done);
      end
      chk("c6_no_done", n_done, 0);
      chk("c6_phase_hold", phases(), 80'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
